gmii_tx_framer: RTL and testbench

- Ethernet MAC transmit framer on the GMII transmit side, ahead of the GMII-to-RGMII converter.
- Accepts a frame payload as a byte stream (destination MAC through end of data, no FCS) over a valid/ready handshake.
- Emits on GMII, in order: preamble, SFD, payload, zero padding up to the minimum length, and CRC32 FCS.
- Enforces the inter-frame gap between frames.

---
 rtl/eth_pkg.sv | 20 ++
 rtl/crc32_d8.sv | 37 +++
 rtl/gmii_tx_framer.sv | 169 ++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet MAC definitions.
// Framer states and frame/CRC constants.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC32, one byte per clock.
// Register holds the running (non-inverted) remainder.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  // next remainder over one byte, LSB first
  always_comb begin
    crc_next = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ?
        ((crc_next >> 1) ^ CRC_POLY_REFL) :
        (crc_next >> 1);
    end
  end

  // remainder register, clear wins over update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload,
// zero pad, FCS and inter-frame gap.
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       sys_rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [31:0] PRE_L = 32'(PREAMBLE_LEN);
  localparam logic [31:0] MIN_L = 32'(MIN_PAYLOAD);
  localparam logic [31:0] IFG_L = 32'(IFG_CYCLES);

  // state names the byte loaded into gmii_txd at the next edge
  tx_state_e   state, state_n;
  logic [7:0]  pre_cnt, pre_n, pre_inc;
  logic [15:0] byte_cnt, cnt_n, cnt_inc;
  logic [2:0]  fcs_idx, fcs_n;
  logic [7:0]  ifg_cnt, ifg_n;
  logic        en_n, busy_n, done_n, err_n;
  logic [7:0]  txd_n;
  logic        crc_clr, crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc, crc_inv;

  assign pre_inc = pre_cnt + 8'd1;
  assign cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt
                                          : byte_cnt + 16'd1;
  assign crc_inv = ~crc;
  assign crc_clr = (state == ST_IDLE);
  assign s_ready = (state == ST_PAYLOAD);

  crc32_d8 u_crc (
    .clk   (gmii_tx_clk),
    .rst_n (sys_rst_n),
    .clear (crc_clr),
    .en    (crc_en),
    .data  (crc_din),
    .crc   (crc)
  );

  // next state and next registered outputs
  always_comb begin
    state_n = state;
    pre_n   = pre_cnt;
    cnt_n   = byte_cnt;
    fcs_n   = fcs_idx;
    ifg_n   = ifg_cnt;
    en_n    = 1'b0;
    txd_n   = 8'h00;
    busy_n  = tx_busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    crc_en  = 1'b0;
    crc_din = 8'h00;
    unique case (state)
      ST_IDLE: begin
        if (s_valid) begin
          en_n    = 1'b1;
          txd_n   = ETH_PREAMBLE;
          busy_n  = 1'b1;
          pre_n   = 8'd1;
          cnt_n   = 16'd0;
          fcs_n   = 3'd0;
          state_n = (PRE_L > 32'd1) ? ST_PREAMBLE : ST_SFD;
        end
      end
      ST_PREAMBLE: begin
        en_n  = 1'b1;
        txd_n = ETH_PREAMBLE;
        pre_n = pre_inc;
        if ({24'd0, pre_inc} >= PRE_L) begin
          state_n = ST_SFD;
        end
      end
      ST_SFD: begin
        en_n    = 1'b1;
        txd_n   = ETH_SFD;
        state_n = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (s_valid) begin
          en_n    = 1'b1;
          txd_n   = s_data;
          crc_en  = 1'b1;
          crc_din = s_data;
          cnt_n   = cnt_inc;
          if (s_last) begin
            state_n = ({16'd0, cnt_inc} < MIN_L) ? ST_PAD : ST_FCS;
          end
        end else begin
          err_n   = 1'b1;
          ifg_n   = 8'd0;
          state_n = ST_IFG;
        end
      end
      ST_PAD: begin
        en_n   = 1'b1;
        crc_en = 1'b1;
        cnt_n  = cnt_inc;
        if ({16'd0, cnt_inc} >= MIN_L) begin
          state_n = ST_FCS;
        end
      end
      ST_FCS: begin
        if (fcs_idx[2]) begin
          done_n  = 1'b1;
          ifg_n   = 8'd0;
          state_n = ST_IFG;
        end else begin
          en_n  = 1'b1;
          txd_n = crc_inv[{fcs_idx[1:0], 3'b000} +: 8];
          fcs_n = fcs_idx + 3'd1;
        end
      end
      ST_IFG: begin
        // the IDLE cycle is the last low cycle of the gap
        if ({24'd0, ifg_cnt} + 32'd2 >= IFG_L) begin
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end else begin
          ifg_n = ifg_cnt + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state, counters and registered GMII outputs
  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      pre_cnt    <= 8'd0;
      byte_cnt   <= 16'd0;
      fcs_idx    <= 3'd0;
      ifg_cnt    <= 8'd0;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state      <= state_n;
      pre_cnt    <= pre_n;
      byte_cnt   <= cnt_n;
      fcs_idx    <= fcs_n;
      ifg_cnt    <= ifg_n;
      gmii_tx_en <= en_n;
      gmii_txd   <= txd_n;
      tx_busy    <= busy_n;
      tx_done    <= done_n;
      tx_err     <= err_n;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer.
// Scoreboard of expected GMII bytes per DUT.
module tb_gmii_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       va = 1'b0;
  logic       vb = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;

  logic       ready_a, en_a, busy_a, done_a, err_a;
  logic [7:0] txd_a;
  logic       ready_b, en_b, busy_b, done_b, err_b;
  logic [7:0] txd_b;

  always #4 clk = ~clk;

  gmii_tx_framer #(
    .PREAMBLE_LEN (7),
    .MIN_PAYLOAD  (0),
    .IFG_CYCLES   (12)
  ) dut_a (
    .gmii_tx_clk (clk),
    .sys_rst_n   (rst_n),
    .s_valid     (va),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (ready_a),
    .gmii_tx_en  (en_a),
    .gmii_txd    (txd_a),
    .tx_busy     (busy_a),
    .tx_done     (done_a),
    .tx_err      (err_a)
  );

  gmii_tx_framer dut_b (
    .gmii_tx_clk (clk),
    .sys_rst_n   (rst_n),
    .s_valid     (vb),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (ready_b),
    .gmii_tx_en  (en_b),
    .gmii_txd    (txd_b),
    .tx_busy     (busy_b),
    .tx_done     (done_b),
    .tx_err      (err_b)
  );

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] pl[$];

  int   run_a = 0, len_a = 0, done_a_n = 0;
  logic prev_a = 1'b0;
  int   run_b = 0, len_b = 0, low_b = 0, gap_b = 0;
  int   rdy_b = 0, rdy_low_b = 0, done_b_n = 0, err_b_n = 0;
  logic prev_b = 1'b0;

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic void push_exp(input bit sel, input logic [7:0] b);
    if (sel) exp_a.push_back(b);
    else     exp_b.push_back(b);
  endfunction

  // expected wire bytes for pl; ncut>=0 means aborted after ncut bytes
  function automatic void push_frame(input bit sel, input int ncut);
    logic [31:0] c;
    int n;
    int mn;
    c  = 32'hFFFFFFFF;
    n  = (ncut >= 0) ? ncut : pl.size();
    mn = sel ? 0 : 60;
    for (int i = 0; i < 7; i++) push_exp(sel, 8'h55);
    push_exp(sel, 8'hD5);
    for (int i = 0; i < n; i++) begin
      push_exp(sel, pl[i]);
      c = crc_upd(c, pl[i]);
    end
    if (ncut < 0) begin
      for (int i = n; i < mn; i++) begin
        push_exp(sel, 8'h00);
        c = crc_upd(c, 8'h00);
      end
      c = ~c;
      push_exp(sel, c[7:0]);
      push_exp(sel, c[15:8]);
      push_exp(sel, c[23:16]);
      push_exp(sel, c[31:24]);
    end
  endfunction

  function automatic void fill_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endfunction

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_a = 1'b0; run_a = 0;
        prev_b = 1'b0; run_b = 0; low_b = 0;
      end else begin
        if (en_a) begin
          n_checks++;
          if (exp_a.size() == 0) begin
            $display("FAIL a_byte: got %02h with tx_en high, required tx_en low", txd_a);
          end else begin
            e = exp_a.pop_front();
            if (txd_a !== e) $display("FAIL a_byte: got %02h, required %02h", txd_a, e);
            else n_pass++;
          end
          run_a++;
        end else if (prev_a) begin
          len_a = run_a;
          run_a = 0;
        end
        if (done_a) done_a_n++;
        prev_a = en_a;

        if (ready_b) rdy_b++;
        if (done_b) done_b_n++;
        if (err_b) err_b_n++;
        n_checks++;
        if (en_b) begin
          if (!prev_b) gap_b = low_b;
          low_b = 0;
          if (exp_b.size() == 0) begin
            $display("FAIL b_byte: got %02h with tx_en high, required tx_en low", txd_b);
          end else begin
            e = exp_b.pop_front();
            if (txd_b !== e) $display("FAIL b_byte: got %02h, required %02h", txd_b, e);
            else n_pass++;
          end
          run_b++;
        end else begin
          if (prev_b) begin
            len_b = run_b;
            run_b = 0;
          end
          low_b++;
          if (ready_b) rdy_low_b++;
          if (txd_b !== 8'h00) $display("FAIL b_idle_txd: got %02h, required 00", txd_b);
          else n_pass++;
        end
        prev_b = en_b;
      end
    end
  endtask

  task automatic drive_frame(input bit sel, input int ncut, input bit keep);
    int n;
    int t;
    n = (ncut >= 0) ? ncut : pl.size();
    if (sel) va = 1'b1;
    else     vb = 1'b1;
    s_data = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge clk);
      while (!(sel ? ready_a : ready_b) && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        n_checks++;
        $display("FAIL drive_timeout: s_ready 0 for %0d cycles, required 1", t);
        va = 1'b0;
        vb = 1'b0;
        return;
      end
      s_data = pl[i];
      s_last = (ncut < 0) && (i == n - 1);
      @(posedge clk);
      #1;
      s_data = 8'($urandom);
      s_last = 1'b0;
    end
    if (!keep) begin
      va = 1'b0;
      vb = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit sel);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((sel ? busy_a : busy_b) && t < 600);
    n_checks++;
    if (sel ? busy_a : busy_b) $display("FAIL idle_timeout: tx_busy 1 after %0d cycles, required 0", t);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({en_b, txd_b, ready_b, busy_b, done_b, err_b} !== 13'h0)
      $display("FAIL reset_b: got %04h, required 0000",
               {en_b, txd_b, ready_b, busy_b, done_b, err_b});
    else n_pass++;
    n_checks++;
    if ({en_a, txd_a, ready_a, busy_a, done_a, err_a} !== 13'h0)
      $display("FAIL reset_a: got %04h, required 0000",
               {en_a, txd_a, ready_a, busy_a, done_a, err_a});
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({en_b, busy_b, ready_b} !== 3'b000)
      $display("FAIL idle_after_reset: got %03b, required 000", {en_b, busy_b, ready_b});
    else n_pass++;
  endtask

  task automatic test_crc();
    int d0;
    logic [7:0] fcs[4];
    fcs = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
    for (int i = 0; i < 7; i++) exp_a.push_back(8'h55);
    exp_a.push_back(8'hD5);
    for (int i = 0; i < 9; i++) exp_a.push_back(pl[i]);
    for (int i = 0; i < 4; i++) exp_a.push_back(fcs[i]);
    d0 = done_a_n;
    drive_frame(1'b1, -1, 1'b0);
    wait_idle(1'b1);
    n_checks++;
    if (exp_a.size() != 0) $display("FAIL crc_missing: %0d bytes unsent, required 0", exp_a.size());
    else n_pass++;
    n_checks++;
    if (len_a != 21) $display("FAIL crc_len: tx_en high %0d cycles, required 21", len_a);
    else n_pass++;
    n_checks++;
    if (done_a_n - d0 != 1) $display("FAIL crc_done: %0d pulses, required 1", done_a_n - d0);
    else n_pass++;
  endtask

  task automatic test_padding();
    int d0, r0, l0;
    fill_pl(14);
    push_frame(1'b0, -1);
    d0 = done_b_n; r0 = rdy_b; l0 = rdy_low_b;
    drive_frame(1'b0, -1, 1'b0);
    wait_idle(1'b0);
    n_checks++;
    if (exp_b.size() != 0) $display("FAIL pad_missing: %0d bytes unsent, required 0", exp_b.size());
    else n_pass++;
    n_checks++;
    if (len_b != 72) $display("FAIL pad_len: tx_en high %0d cycles, required 72", len_b);
    else n_pass++;
    n_checks++;
    if (rdy_b - r0 != 14) $display("FAIL pad_ready: s_ready high %0d cycles, required 14", rdy_b - r0);
    else n_pass++;
    n_checks++;
    if (rdy_low_b - l0 != 0) $display("FAIL pad_ready_idle: %0d cycles, required 0", rdy_low_b - l0);
    else n_pass++;
    n_checks++;
    if (done_b_n - d0 != 1) $display("FAIL pad_done: %0d pulses, required 1", done_b_n - d0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0, r0, l0;
    fill_pl(64);
    push_frame(1'b0, -1);
    d0 = done_b_n; r0 = rdy_b; l0 = rdy_low_b;
    drive_frame(1'b0, -1, 1'b1);
    fill_pl(64);
    push_frame(1'b0, -1);
    drive_frame(1'b0, -1, 1'b0);
    wait_idle(1'b0);
    n_checks++;
    if (exp_b.size() != 0) $display("FAIL b2b_missing: %0d bytes unsent, required 0", exp_b.size());
    else n_pass++;
    n_checks++;
    if (gap_b != 12) $display("FAIL b2b_gap: %0d low cycles, required 12", gap_b);
    else n_pass++;
    n_checks++;
    if (rdy_low_b - l0 != 0) $display("FAIL b2b_ready_gap: %0d cycles, required 0", rdy_low_b - l0);
    else n_pass++;
    n_checks++;
    if (rdy_b - r0 != 128) $display("FAIL b2b_ready: %0d cycles, required 128", rdy_b - r0);
    else n_pass++;
    n_checks++;
    if (len_b != 76) $display("FAIL b2b_len: %0d cycles, required 76", len_b);
    else n_pass++;
    n_checks++;
    if (done_b_n - d0 != 2) $display("FAIL b2b_done: %0d pulses, required 2", done_b_n - d0);
    else n_pass++;
  endtask

  task automatic test_underrun();
    int d0, e0, r0;
    fill_pl(30);
    push_frame(1'b0, 20);
    d0 = done_b_n; e0 = err_b_n; r0 = rdy_b;
    drive_frame(1'b0, 20, 1'b0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_b.size() != 0) $display("FAIL urun_missing: %0d bytes unsent, required 0", exp_b.size());
    else n_pass++;
    n_checks++;
    if (len_b != 28) $display("FAIL urun_len: %0d cycles, required 28", len_b);
    else n_pass++;
    n_checks++;
    if (err_b_n - e0 != 1) $display("FAIL urun_err: %0d pulses, required 1", err_b_n - e0);
    else n_pass++;
    n_checks++;
    if (rdy_b - r0 != 21) $display("FAIL urun_ready: %0d cycles, required 21", rdy_b - r0);
    else n_pass++;
    fill_pl(60);
    push_frame(1'b0, -1);
    drive_frame(1'b0, -1, 1'b0);
    wait_idle(1'b0);
    n_checks++;
    if (gap_b != 12) $display("FAIL urun_gap: %0d low cycles, required 12", gap_b);
    else n_pass++;
    n_checks++;
    if (exp_b.size() != 0) $display("FAIL urun_next: %0d bytes unsent, required 0", exp_b.size());
    else n_pass++;
    n_checks++;
    if (done_b_n - d0 != 1) $display("FAIL urun_done: %0d pulses, required 1", done_b_n - d0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int d0, e0;
    fill_pl(14);
    push_frame(1'b0, -1);
    d0 = done_b_n; e0 = err_b_n;
    drive_frame(1'b0, -1, 1'b0);
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({en_b, txd_b, ready_b, busy_b, done_b, err_b} !== 13'h0)
      $display("FAIL async_reset: got %04h, required 0000",
               {en_b, txd_b, ready_b, busy_b, done_b, err_b});
    else n_pass++;
    exp_b.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ((done_b_n - d0) + (err_b_n - e0) != 0)
      $display("FAIL reset_pulses: %0d done/err pulses, required 0",
               (done_b_n - d0) + (err_b_n - e0));
    else n_pass++;
    repeat (2) @(negedge clk);
    fill_pl(60);
    push_frame(1'b0, -1);
    drive_frame(1'b0, -1, 1'b0);
    wait_idle(1'b0);
    n_checks++;
    if (exp_b.size() != 0) $display("FAIL reset_fcs: %0d bytes unsent, required 0", exp_b.size());
    else n_pass++;
    n_checks++;
    if (len_b != 72) $display("FAIL reset_len: %0d cycles, required 72", len_b);
    else n_pass++;
    n_checks++;
    if (done_b_n - d0 != 1) $display("FAIL reset_done: %0d pulses, required 1", done_b_n - d0);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_crc();
    test_padding();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
